// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - multi-read-port register file with per-register busy scoreboard.
// Optional same-cycle write-to-read bypass enabled by defining REGFILE_BYPASS_EN.
module regfile_scoreboard #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  output logic                     stall,
  output logic [ADDR_W:0]          pending_cnt
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] CNT_MAX = (ADDR_W + 1)'(DEPTH - 1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              wr_ok, rsv_ok, cnt_inc, cnt_dec;

  // Index 0 is hardwired, so both events are dropped for it.
  assign wr_ok  = wr_en  && (wr_addr  != '0);
  assign rsv_ok = rsv_en && (rsv_addr != '0);

  always_comb begin
    busy_d = busy_q;
    if (wr_ok)  busy_d[wr_addr]  = 1'b0;
    if (rsv_ok) busy_d[rsv_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // A write to the register being re-reserved keeps it busy, so it is not a clear.
  assign cnt_inc = rsv_ok && !busy_q[rsv_addr];
  assign cnt_dec = wr_ok && busy_q[wr_addr] && !(rsv_ok && (rsv_addr == wr_addr));

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_inc && !cnt_dec && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end else if (cnt_dec && !cnt_inc && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (wr_ok) begin
        mem_q[wr_addr] <= wr_data;
      end
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign pending_cnt = cnt_q;

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    assign addr = rd_addr[p*ADDR_W +: ADDR_W];
`ifdef REGFILE_BYPASS_EN
    logic hit, rsv_same;
    assign hit      = wr_ok && (wr_addr == addr);
    assign rsv_same = rsv_en && (rsv_addr == wr_addr);
    assign rd_data[p*DATA_W +: DATA_W] = hit ? wr_data : mem_q[addr];
    assign rd_busy[p] = (hit && !rsv_same) ? 1'b0 : busy_q[addr];
`else
    assign rd_data[p*DATA_W +: DATA_W] = mem_q[addr];
    assign rd_busy[p] = busy_q[addr];
`endif
  end

  assign stall = |(rd_en & rd_busy);

endmodule
